// File: rtl/data_ram_resp_pkg.sv
// rtl/data_ram_resp_pkg.sv - shared types, FSM encodings and bus constants for the data RAM responder
package data_ram_resp_pkg;

  localparam int DATA_MEM_NUM_LOG2 = 10;

  typedef logic [31:0] data_addr_bus_t;
  typedef logic [31:0] data_bus_t;

  localparam logic      RST_ENABLE   = 1'b1;
  localparam logic      CHIP_ENABLE  = 1'b1;
  localparam logic      WRITE_ENABLE = 1'b1;
  localparam data_bus_t ZERO_WORD    = 32'h0000_0000;

  typedef enum logic [1:0] {
    DRESP_IDLE = 2'd0,
    DRESP_WAIT = 2'd1,
    DRESP_RESP = 2'd2
  } dresp_state_e;

endpackage

// File: rtl/data_ram_resp_if.sv
// rtl/data_ram_resp_if.sv - MEM-stage RAM port between the pipeline (master) and the responder (slave)
interface data_ram_resp_if;
  import data_ram_resp_pkg::*;

  logic           ce_i;
  logic           we_i;
  data_addr_bus_t addr_i;
  logic [3:0]     sel_i;
  data_bus_t      data_i;
  logic           flush_i;
  data_bus_t      data_o;
  logic           stallreq_o;

  modport master (
    output ce_i, we_i, addr_i, sel_i, data_i, flush_i,
    input  data_o, stallreq_o
  );

  modport slave (
    input  ce_i, we_i, addr_i, sel_i, data_i, flush_i,
    output data_o, stallreq_o
  );

endinterface

// File: rtl/data_ram_array.sv
// rtl/data_ram_array.sv - four 8-bit banks with per-lane write enable and asynchronous read
module data_ram_array
  import data_ram_resp_pkg::*;
#(
  parameter int ADDR_WIDTH = DATA_MEM_NUM_LOG2
) (
  input  logic                  clk,
  input  logic [3:0]            we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  data_bus_t             data_i,
  output data_bus_t             data_o
);

  for (genvar n = 0; n < 4; n++) begin : g_lane
    logic [7:0] bank_q [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
      if (we_i[n]) begin
        bank_q[addr_i] <= data_i[8*n +: 8];
      end
    end

    assign data_o[8*n +: 8] = bank_q[addr_i];
  end

endmodule

// File: rtl/data_ram_resp.sv
// rtl/data_ram_resp.sv - latency-inserting data RAM responder: wait FSM, flush/abort and output muxing
module data_ram_resp
  import data_ram_resp_pkg::*;
#(
  parameter int ADDR_WIDTH  = DATA_MEM_NUM_LOG2,
  parameter int WAIT_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst,
  data_ram_resp_if.slave bus
);

  dresp_state_e          state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  stall;
  logic                  resp;
  logic [3:0]            lane_we;
  logic [ADDR_WIDTH-1:0] word_addr;
  data_bus_t             rdata;
  logic                  unused_addr;

  assign word_addr   = bus.addr_i[ADDR_WIDTH+1:2];
  assign unused_addr = ^{bus.addr_i[31:ADDR_WIDTH+2], bus.addr_i[1:0]};

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q <= DRESP_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The IDLE cycle already stalls, so WAIT leaves once cnt reaches 1 to keep exactly WAIT_CYCLES stalls.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    resp    = 1'b0;
    case (state_q)
      DRESP_IDLE: begin
        if (bus.ce_i == CHIP_ENABLE) begin
          if (WAIT_CYCLES == 0) begin
            resp = 1'b1;
          end else begin
            stall   = 1'b1;
            state_d = (WAIT_CYCLES == 1) ? DRESP_RESP : DRESP_WAIT;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end
        end
      end
      DRESP_WAIT: begin
        if (bus.ce_i != CHIP_ENABLE) begin
          state_d = DRESP_IDLE;
          cnt_d   = 4'd0;
        end else begin
          stall = 1'b1;
          if (cnt_q <= 4'd1) begin
            state_d = DRESP_RESP;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      DRESP_RESP: begin
        resp    = (bus.ce_i == CHIP_ENABLE);
        state_d = DRESP_IDLE;
      end
      default: begin
        state_d = DRESP_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
    if (bus.flush_i || rst == RST_ENABLE) begin
      state_d = DRESP_IDLE;
      cnt_d   = 4'd0;
      stall   = 1'b0;
      resp    = 1'b0;
    end
  end

  assign lane_we = (resp && bus.we_i == WRITE_ENABLE) ? bus.sel_i : 4'b0000;

  data_ram_array #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .clk    (clk),
    .we_i   (lane_we),
    .addr_i (word_addr),
    .data_i (bus.data_i),
    .data_o (rdata)
  );

  assign bus.stallreq_o = stall;
  assign bus.data_o     = (resp && bus.we_i != WRITE_ENABLE) ? rdata : ZERO_WORD;

endmodule

// File: tb/tb_data_ram_resp.sv
// tb/tb_data_ram_resp.sv - directed self-checking bench for data_ram_resp at WAIT_CYCLES 2 and 0
module tb_data_ram_resp;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  data_ram_resp_if ifa ();
  data_ram_resp_if ifb ();

  data_ram_resp #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) dut_a (.clk(clk), .rst(rst_a), .bus(ifa.slave));
  data_ram_resp #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut_b (.clk(clk), .rst(rst_b), .bus(ifb.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc_a(input logic ce, input logic we, input logic [31:0] addr,
                       input logic [3:0] sel, input logic [31:0] data, input logic flush);
    @(posedge clk);
    #1;
    ifa.ce_i = ce; ifa.we_i = we; ifa.addr_i = addr;
    ifa.sel_i = sel; ifa.data_i = data; ifa.flush_i = flush;
    @(negedge clk);
  endtask

  task automatic cyc_b(input logic ce, input logic we, input logic [31:0] addr,
                       input logic [3:0] sel, input logic [31:0] data, input logic flush);
    @(posedge clk);
    #1;
    ifb.ce_i = ce; ifb.we_i = we; ifb.addr_i = addr;
    ifb.sel_i = sel; ifb.data_i = data; ifb.flush_i = flush;
    @(negedge clk);
  endtask

  task automatic acc_a(input string tag, input logic we, input logic [31:0] addr,
                       input logic [3:0] sel, input logic [31:0] data, input logic [31:0] exp);
    cyc_a(1'b1, we, addr, sel, data, 1'b0);
    chk({tag, " stall c1"}, 32'(ifa.stallreq_o), 32'd1);
    chk({tag, " data c1"}, ifa.data_o, 32'h0);
    cyc_a(1'b1, we, addr, sel, data, 1'b0);
    chk({tag, " stall c2"}, 32'(ifa.stallreq_o), 32'd1);
    cyc_a(1'b1, we, addr, sel, data, 1'b0);
    chk({tag, " stall c3"}, 32'(ifa.stallreq_o), 32'd0);
    chk({tag, " data c3"}, ifa.data_o, exp);
    cyc_a(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    chk({tag, " stall idle"}, 32'(ifa.stallreq_o), 32'd0);
  endtask

  initial begin
    ifa.ce_i = 0; ifa.we_i = 0; ifa.addr_i = 0; ifa.sel_i = 0; ifa.data_i = 0; ifa.flush_i = 0;
    ifb.ce_i = 0; ifb.we_i = 0; ifb.addr_i = 0; ifb.sel_i = 0; ifb.data_i = 0; ifb.flush_i = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_a = 1'b0;
    rst_b = 1'b0;
    @(negedge clk);
    chk("reset stall a", 32'(ifa.stallreq_o), 32'd0);
    chk("reset data a", ifa.data_o, 32'h0);
    chk("reset stall b", 32'(ifb.stallreq_o), 32'd0);
    chk("reset data b", ifb.data_o, 32'h0);

    acc_a("sw100", 1'b1, 32'h100, 4'b1111, 32'hDEADBEEF, 32'h0);
    acc_a("lw100", 1'b0, 32'h100, 4'b1111, 32'h0, 32'hDEADBEEF);

    acc_a("sb101", 1'b1, 32'h101, 4'b0010, 32'h5A5A5A5A, 32'h0);
    acc_a("lw100 sb", 1'b0, 32'h100, 4'b1111, 32'h0, 32'hDEAD5AEF);

    acc_a("sw sel0", 1'b1, 32'h100, 4'b0000, 32'hFFFFFFFF, 32'h0);
    acc_a("lw100 sel0", 1'b0, 32'h100, 4'b1111, 32'h0, 32'hDEAD5AEF);

    acc_a("sw104 pre", 1'b1, 32'h104, 4'b1111, 32'h0BADCAFE, 32'h0);
    cyc_a(1'b1, 1'b1, 32'h104, 4'b1111, 32'h11111111, 1'b0);
    chk("flush stall c1", 32'(ifa.stallreq_o), 32'd1);
    cyc_a(1'b1, 1'b1, 32'h104, 4'b1111, 32'h11111111, 1'b1);
    chk("flush stall c2", 32'(ifa.stallreq_o), 32'd0);
    cyc_a(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    chk("flush stall idle", 32'(ifa.stallreq_o), 32'd0);
    acc_a("lw104 flush", 1'b0, 32'h104, 4'b1111, 32'h0, 32'h0BADCAFE);

    acc_a("sw108 pre", 1'b1, 32'h108, 4'b1111, 32'h22222222, 32'h0);
    cyc_a(1'b1, 1'b1, 32'h108, 4'b1111, 32'h33333333, 1'b0);
    chk("rst stall c1", 32'(ifa.stallreq_o), 32'd1);
    @(posedge clk);
    #1;
    rst_a = 1'b1;
    @(posedge clk);
    #1;
    rst_a = 1'b0;
    ifa.ce_i = 1'b0; ifa.we_i = 1'b0; ifa.addr_i = 32'h0; ifa.sel_i = 4'h0; ifa.data_i = 32'h0;
    @(negedge clk);
    chk("rst stall after", 32'(ifa.stallreq_o), 32'd0);
    acc_a("lw108 rst", 1'b0, 32'h108, 4'b1111, 32'h0, 32'h22222222);
    acc_a("lw100 rst", 1'b0, 32'h100, 4'b1111, 32'h0, 32'hDEAD5AEF);

    acc_a("sw10c pre", 1'b1, 32'h10C, 4'b1111, 32'h55555555, 32'h0);
    cyc_a(1'b1, 1'b1, 32'h10C, 4'b1111, 32'h66666666, 1'b0);
    chk("abort stall c1", 32'(ifa.stallreq_o), 32'd1);
    cyc_a(1'b0, 1'b1, 32'h10C, 4'b1111, 32'h66666666, 1'b0);
    chk("abort stall c2", 32'(ifa.stallreq_o), 32'd0);
    acc_a("lw10c abort", 1'b0, 32'h10C, 4'b1111, 32'h0, 32'h55555555);

    acc_a("sw1000", 1'b1, 32'h1000, 4'b1111, 32'hCAFEF00D, 32'h0);
    acc_a("lw0000 alias", 1'b0, 32'h0000, 4'b1111, 32'h0, 32'hCAFEF00D);
    acc_a("lw0003 alias", 1'b0, 32'h0003, 4'b1111, 32'h0, 32'hCAFEF00D);

    cyc_b(1'b1, 1'b1, 32'h200, 4'b1111, 32'h12345678, 1'b0);
    chk("b sw stall", 32'(ifb.stallreq_o), 32'd0);
    chk("b sw data", ifb.data_o, 32'h0);
    cyc_b(1'b1, 1'b0, 32'h200, 4'b1111, 32'h0, 1'b0);
    chk("b lw stall", 32'(ifb.stallreq_o), 32'd0);
    chk("b lw data", ifb.data_o, 32'h12345678);
    cyc_b(1'b1, 1'b1, 32'h203, 4'b1000, 32'hAAAAAAAA, 1'b0);
    chk("b sb stall", 32'(ifb.stallreq_o), 32'd0);
    cyc_b(1'b1, 1'b0, 32'h200, 4'b1111, 32'h0, 1'b0);
    chk("b lw sb data", ifb.data_o, 32'hAA345678);
    cyc_b(1'b1, 1'b0, 32'h200, 4'b1111, 32'h0, 1'b1);
    chk("b lw flush data", ifb.data_o, 32'h0);
    cyc_b(1'b0, 1'b0, 32'h200, 4'b1111, 32'h0, 1'b0);
    chk("b idle data", ifb.data_o, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
